// File: rtl/calc_div_seq.sv
// Sequential restoring divider, one quotient bit per cycle, with signed/unsigned modes.
// Divide-by-zero and signed MIN/-1 overflow are flagged alongside the result.
module calc_div_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_zero,
    output logic             overflow
);

    localparam int               CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIN = 2'd2} state_t;

    function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   dvd_q, dvs_q, rem_q;
    logic               qsign_q, rsign_q, dz_q, ovf_q;
    logic               done_q, dzo_q, ovo_q;
    logic [WIDTH-1:0]   q_q, r_q;
    logic               accept;
    logic [WIDTH:0]     rem_sh, diff;

    assign accept = (state_q == IDLE) && !done_q && start;

    // The sign of the trial subtraction doubles as the restoring compare.
    assign rem_sh = {rem_q, dvd_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (b == '0) ? FIN : CALC;
            CALC:    if (cnt_q == LAST) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done_q <= 1'b0;
            cnt_q  <= '0;
            q_q    <= '0;
            r_q    <= '0;
            dzo_q  <= 1'b0;
            ovo_q  <= 1'b0;
        end else begin
            done_q <= (state_q == FIN);
            if (accept) begin
                cnt_q <= '0;
                dzo_q <= 1'b0;
                ovo_q <= 1'b0;
            end else if (state_q == CALC) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == FIN) begin
                q_q   <= dz_q ? '1 : neg_if(dvd_q, qsign_q);
                r_q   <= dz_q ? dvd_q : neg_if(rem_q, rsign_q);
                dzo_q <= dz_q;
                ovo_q <= ovf_q;
            end
        end
    end

    // Dividend register shifts out dividend bits and shifts in quotient bits.
    always_ff @(posedge clk) begin
        if (accept) begin
            dvd_q   <= (b == '0) ? a : neg_if(a, signed_mode & a[WIDTH-1]);
            dvs_q   <= neg_if(b, signed_mode & b[WIDTH-1]);
            rem_q   <= '0;
            qsign_q <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            rsign_q <= signed_mode & a[WIDTH-1];
            dz_q    <= (b == '0);
            ovf_q   <= signed_mode && (a == MIN_V) && (b == '1);
        end else if (state_q == CALC) begin
            rem_q <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
            dvd_q <= {dvd_q[WIDTH-2:0], ~diff[WIDTH]};
        end
    end

    assign done     = done_q;
    assign q        = q_q;
    assign r        = r_q;
    assign div_zero = dzo_q;
    assign overflow = ovo_q;

endmodule

// File: tb/tb_calc_div_seq.sv
// Randomised and directed bench for calc_div_seq against a transaction-level
// division model; outputs are compared every cycle on the falling edge.
module tb_calc_div_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, signed_mode;
    logic [W-1:0] a, b;
    logic         busy, done, div_zero, overflow;
    logic [W-1:0] q, r;

    int checks = 0;
    int errors = 0;

    calc_div_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done), .q(q), .r(r),
        .div_zero(div_zero), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain arithmetic reference: SV integer division truncates toward zero
    // and the remainder takes the dividend's sign.
    function automatic void model_div(input bit sm, input logic [W-1:0] av, input logic [W-1:0] bv,
                                      output logic [W-1:0] mq, output logic [W-1:0] mr,
                                      output bit mdz, output bit mov);
        longint sa, sb, qq, rr;
        mdz = 1'b0;
        mov = 1'b0;
        if (bv == '0) begin
            mq  = '1;
            mr  = av;
            mdz = 1'b1;
        end else begin
            if (sm) begin
                sa = longint'($signed(av));
                sb = longint'($signed(bv));
                if (sa == -(longint'(1) << (W - 1)) && sb == -1) mov = 1'b1;
            end else begin
                sa = longint'(av);
                sb = longint'(bv);
            end
            qq = sa / sb;
            rr = sa % sb;
            mq = W'(qq);
            mr = W'(rr);
        end
    endfunction

    // Transaction-level model of acceptance, latency and held results.
    int           edge_n = 0;
    bit           m_pend = 0, m_done = 0, prev_done;
    int           m_due;
    logic [W-1:0] m_q = '0, m_r = '0, p_q, p_r;
    bit           m_dz = 0, m_ov = 0, p_dz, p_ov;
    bit           chk_en = 0;

    always @(posedge clk) begin
        edge_n++;
        prev_done = m_done;
        m_done = 1'b0;
        if (rst) begin
            m_pend = 0; m_q = '0; m_r = '0; m_dz = 0; m_ov = 0;
        end else if (m_pend && edge_n == m_due) begin
            m_pend = 0; m_done = 1; m_q = p_q; m_r = p_r; m_dz = p_dz; m_ov = p_ov;
        end else if (!m_pend && !prev_done && start) begin
            model_div(signed_mode, a, b, p_q, p_r, p_dz, p_ov);
            m_pend = 1;
            m_due  = edge_n + ((b == '0) ? 1 : W + 1);
            m_dz = 0; m_ov = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, m_pend);
            chk("done", done, m_done);
            chk("q", q, m_q);
            chk("r", r, m_r);
            chk("div_zero", div_zero, m_dz);
            chk("overflow", overflow, m_ov);
        end
    end

    // Starts an operation one cycle after the call; extra_at>0 re-pulses start
    // with junk operands that many cycles after acceptance.
    task automatic do_op(input bit sm, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input int extra_at,
                         output logic [W-1:0] oq, output logic [W-1:0] orr,
                         output bit odz, output bit oov, output int lat);
        int  cnt;
        bit  got;
        @(negedge clk);
        signed_mode = sm; a = av; b = bv; start = 1'b1;
        cnt = 0; got = 0;
        while (!got && cnt < 60) begin
            @(negedge clk);
            cnt++;
            start = 1'b0;
            if (extra_at > 0 && cnt == extra_at) begin
                start = 1'b1; a = W'($urandom); b = W'($urandom);
                signed_mode = 1'($urandom);
            end
            if (done) got = 1;
        end
        start = 1'b0;
        if (got) begin
            oq = q; orr = r; odz = div_zero; oov = overflow; lat = cnt - 1;
        end else begin
            chk("done_timeout", 0, 1);
            oq = 'x; orr = 'x; odz = 0; oov = 0; lat = -1;
        end
    endtask

    initial begin
        logic [W-1:0] rq, rr, av, bv;
        bit           rdz, rov;
        int           lat, seen;

        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", q, 0);
        chk("rst_r", r, 0);
        rst = 1'b0;

        model_div(0, 8'd200, 8'd7, rq, rr, rdz, rov);
        chk("model_u200_7", {rq, rr, 6'(rdz), 2'(rov)}, {8'd28, 8'd4, 8'd0});
        model_div(1, 8'h9C, 8'd7, rq, rr, rdz, rov);
        chk("model_sm100_7", {rq, rr}, {8'hF2, 8'hFE});
        model_div(1, 8'd100, 8'hF9, rq, rr, rdz, rov);
        chk("model_s100_m7", {rq, rr}, {8'hF2, 8'h02});
        model_div(0, 8'h55, 8'h00, rq, rr, rdz, rov);
        chk("model_div0", {rq, rr, 6'(rdz), 2'(rov)}, {8'hFF, 8'h55, 8'h04});
        model_div(1, 8'h80, 8'hFF, rq, rr, rdz, rov);
        chk("model_ovf", {rq, rr, 6'(rdz), 2'(rov)}, {8'h80, 8'h00, 8'h01});

        do_op(0, 8'd200, 8'd7, 0, rq, rr, rdz, rov, lat);
        chk("u200_7_q", rq, 8'd28);
        chk("u200_7_r", rr, 8'd4);
        chk("u200_7_flags", {rdz, rov}, 2'b00);
        chk("u200_7_lat", lat, 9);

        do_op(1, 8'h9C, 8'd7, 0, rq, rr, rdz, rov, lat);
        chk("sm100_7_qr", {rq, rr}, {8'hF2, 8'hFE});
        do_op(1, 8'd100, 8'hF9, 0, rq, rr, rdz, rov, lat);
        chk("s100_m7_qr", {rq, rr}, {8'hF2, 8'h02});

        do_op(0, 8'h55, 8'h00, 0, rq, rr, rdz, rov, lat);
        chk("div0_qr", {rq, rr}, {8'hFF, 8'h55});
        chk("div0_flags", {rdz, rov}, 2'b10);
        chk("div0_lat", lat, 1);

        do_op(1, 8'h80, 8'hFF, 0, rq, rr, rdz, rov, lat);
        chk("ovf_qr", {rq, rr}, {8'h80, 8'h00});
        chk("ovf_flags", {rdz, rov}, 2'b01);

        do_op(0, 8'd200, 8'd7, 3, rq, rr, rdz, rov, lat);
        chk("restart_qr", {rq, rr}, {8'd28, 8'd4});
        chk("restart_lat", lat, 9);

        // Abort with reset four cycles into the operation.
        @(negedge clk);
        signed_mode = 0; a = 8'd200; b = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("abort_no_done", seen, 0);
        chk("abort_outs", {busy, q, r, div_zero, overflow}, 0);
        do_op(1, 8'h9C, 8'd7, 0, rq, rr, rdz, rov, lat);
        chk("after_abort_qr", {rq, rr}, {8'hF2, 8'hFE});
        chk("after_abort_lat", lat, 9);

        for (int n = 0; n < 300; n++) begin
            av = W'($urandom);
            bv = W'($urandom);
            case ($urandom_range(0, 7))
                0: bv = '0;
                1: bv = '1;
                2: av = 8'h80;
                3: begin av = 8'h80; bv = '1; end
                default: ;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b1; a = W'($urandom); b = W'($urandom);
            end
            do_op(1'($urandom), av, bv, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0,
                  rq, rr, rdz, rov, lat);
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
